tile_bank_config_loader: RTL and testbench

Memory-bank configuration loader that sits directly upstream of a tile's bitline/wordline configuration inputs. It accepts the configuration bitstream as a stream of bytes over a valid/ready handshake and assembles one bitline frame at a time. For each frame it drives the full bitline bus, then pulses exactly one wordline to write that frame into the tile. It repeats this for every wordline of the bank, then reports completion.

---
 rtl/tile_bank_config_loader.sv | 120 ++++++++++++
 tb/tb_tile_bank_config_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tile_bank_config_loader.sv
// Streams a byte-wide bitstream into the bitline register one frame at a time,
// then pulses that frame's wordline; repeats for every wordline of the bank.
module tile_bank_config_loader #(
    parameter  int BL_WIDTH   = 315,
    parameter  int WL_WIDTH   = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int WL_PULSE   = 2,
    localparam int FI_W       = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [BL_WIDTH-1:0]   bl,
    output logic [WL_WIDTH-1:0]   wl,
    output logic                  busy,
    output logic                  done,
    output logic [FI_W-1:0]       frame_idx
);

    localparam int WORDS = (BL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS + 1) : 1;
    localparam int PC_W  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_SETTLE, S_PULSE, S_HOLD, S_DONE
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  word_cnt;
    logic [PC_W-1:0]   pulse_cnt;
    logic              load_start, accept, last_word, last_pulse, last_frame;
    logic              cfg_ready_d, busy_d, done_d;
    logic [WL_WIDTH-1:0] wl_d;

    assign load_start = (state == S_IDLE) && start;
    assign accept     = cfg_valid && cfg_ready;
    assign last_word  = (word_cnt == CNT_W'(WORDS - 1));
    assign last_pulse = (pulse_cnt == PC_W'(WL_PULSE - 1));
    assign last_frame = (frame_idx == FI_W'(WL_WIDTH - 1));

    // NOTE: state and every register use non-blocking (<=) assignments so all
    // flops update together from values sampled at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: each always_comb assigns a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (start) next_state = S_SHIFT;
            S_SHIFT:  if (accept && last_word) next_state = S_SETTLE;
            S_SETTLE: next_state = S_PULSE;
            S_PULSE:  if (last_pulse) next_state = S_HOLD;
            S_HOLD:   next_state = last_frame ? S_DONE : S_SHIFT;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they line up
    // with the state they describe and never depend on cfg_valid directly.
    always_comb begin
        cfg_ready_d = (next_state == S_SHIFT);
        busy_d      = (next_state != S_IDLE);
        done_d      = (next_state == S_DONE);
        wl_d        = '0;
        if (next_state == S_PULSE) wl_d = WL_WIDTH'(1) << frame_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wl        <= '0;
            frame_idx <= '0;
            word_cnt  <= '0;
            pulse_cnt <= '0;
        end else begin
            cfg_ready <= cfg_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            wl        <= wl_d;

            if (load_start || state == S_HOLD) word_cnt <= '0;
            else if (accept)                   word_cnt <= word_cnt + 1'b1;

            if (load_start)                      frame_idx <= '0;
            else if (state == S_HOLD && !last_frame) frame_idx <= frame_idx + 1'b1;

            if (state == S_PULSE) pulse_cnt <= pulse_cnt + 1'b1;
            else                  pulse_cnt <= '0;
        end
    end

    // One register slice per input word; the top slice keeps only in-range bits.
    for (genvar g = 0; g < WORDS; g++) begin : g_word
        localparam int LO = g * DATA_WIDTH;
        localparam int N  = (BL_WIDTH - LO < DATA_WIDTH) ? (BL_WIDTH - LO) : DATA_WIDTH;

        logic [N-1:0] word_q;

        // NOTE: the bitline register is ordinary flops, not a RAM, so it takes
        // the async reset like the rest of the state.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)                                        word_q <= '0;
            else if (load_start)                              word_q <= '0;
            else if (accept && word_cnt == CNT_W'(g))         word_q <= cfg_data[N-1:0];
        end

        assign bl[LO +: N] = word_q;
    end

endmodule

// File: tb/tb_tile_bank_config_loader.sv
// Self-checking bench: a cycle trace built from the loader's rules is compared
// against the default instance; a single-word instance covers edge parameters.
module tb_tile_bank_config_loader;

    localparam int BL    = 315;
    localparam int WLW   = 4;
    localparam int DW    = 8;
    localparam int P     = 2;
    localparam int WORDS = (BL + DW - 1) / DW;
    localparam int FRAME_MIN = WORDS + 1 + P + 1;
    localparam int MAXC  = 1024;

    logic          clk = 1'b0;
    logic          reset, start, cfg_valid, cfg_ready, busy, done;
    logic [DW-1:0] cfg_data;
    logic [BL-1:0] bl;
    logic [WLW-1:0] wl;
    logic [1:0]    frame_idx;

    logic       e_start, e_valid, e_ready, e_busy, e_done;
    logic [7:0] e_data, e_bl;
    logic [0:0] e_wl, e_frame;

    always #5 clk = ~clk;

    tile_bank_config_loader dut (
        .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .bl(bl), .wl(wl),
        .busy(busy), .done(done), .frame_idx(frame_idx)
    );

    tile_bank_config_loader #(.BL_WIDTH(8), .WL_WIDTH(1), .DATA_WIDTH(8), .WL_PULSE(1)) dut_e (
        .clk(clk), .reset(reset), .start(e_start), .cfg_data(e_data),
        .cfg_valid(e_valid), .cfg_ready(e_ready), .bl(e_bl), .wl(e_wl),
        .busy(e_busy), .done(e_done), .frame_idx(e_frame)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit counting;
        int stall_len;
        bit ign_start;
        bit rnd_gaps;
        int exp_total;
    } scen_t;

    typedef struct {
        bit         start;
        bit         valid;
        logic [7:0] data;
        logic [12:0] exp;
    } evec_t;

    // Expected per-cycle trace, cycle 0 = first SHIFT cycle.
    logic [8:0]    exp_ctl [MAXC];
    logic [BL-1:0] exp_bl  [MAXC];
    logic          drv_valid [MAXC];
    logic [DW-1:0] drv_data  [MAXC];
    int            end_cyc, pulse0_cyc;

    function automatic logic [8:0] ctl(bit r, bit b, bit d, logic [3:0] w, int f);
        return {r, b, d, w, 2'(f)};
    endfunction

    task automatic put(inout int cyc, input logic [8:0] c, input logic [BL-1:0] v,
                       input logic dv, input logic [DW-1:0] dd);
        exp_ctl[cyc] = c; exp_bl[cyc] = v; drv_valid[cyc] = dv; drv_data[cyc] = dd;
        cyc++;
    endtask

    task automatic build_trace(input scen_t s);
        int cyc = 0;
        logic [BL-1:0] blv = '0;
        for (int f = 0; f < WLW; f++) begin
            for (int w = 0; w < WORDS; w++) begin
                int gap = 0;
                logic [DW-1:0] b;
                if (s.stall_len > 0 && f == 1 && w == 11) gap = s.stall_len;
                else if (s.rnd_gaps && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
                for (int k = 0; k < gap; k++) put(cyc, ctl(1, 1, 0, 4'd0, f), blv, 1'b0, DW'($urandom));
                b = s.counting ? DW'(w) : DW'($urandom);
                put(cyc, ctl(1, 1, 0, 4'd0, f), blv, 1'b1, b);
                for (int k = 0; k < DW; k++) if (w * DW + k < BL) blv[w * DW + k] = b[k];
            end
            put(cyc, ctl(0, 1, 0, 4'd0, f), blv, 1'($urandom), DW'($urandom));
            if (f == 0) pulse0_cyc = cyc;
            for (int k = 0; k < P; k++) put(cyc, ctl(0, 1, 0, 4'(1 << f), f), blv, 1'b1, DW'($urandom));
            put(cyc, ctl(0, 1, 0, 4'd0, f), blv, 1'b1, DW'($urandom));
        end
        end_cyc = cyc;
        put(cyc, ctl(0, 1, 1, 4'd0, WLW - 1), blv, 1'($urandom), DW'($urandom));
        for (int k = 0; k < 3; k++) put(cyc, ctl(0, 0, 0, 4'd0, WLW - 1), blv, 1'($urandom), DW'($urandom));
    endtask

    task automatic run(input scen_t s, input int abort_at, input string tag);
        int done_seen = -1;
        build_trace(s);
        @(negedge clk);
        start = 1'b1; cfg_valid = 1'b0;
        for (int cyc = 0; cyc < end_cyc + 4; cyc++) begin
            @(negedge clk);
            check($sformatf("%s ctl c%0d", tag, cyc), {cfg_ready, busy, done, wl, frame_idx}, exp_ctl[cyc]);
            check($sformatf("%s bl c%0d", tag, cyc), bl, exp_bl[cyc]);
            if (done && done_seen < 0) done_seen = cyc;
            start     = s.ign_start && (cyc == 5 || cyc == pulse0_cyc);
            cfg_valid = drv_valid[cyc];
            cfg_data  = drv_data[cyc];
            if (cyc == abort_at) begin
                @(posedge clk);
                #2 reset = 1'b1;
                #1 check($sformatf("%s async reset", tag),
                         {bl, wl, cfg_ready, busy, done, frame_idx}, '0);
                @(negedge clk);
                reset = 1'b0; start = 1'b0; cfg_valid = 1'b0;
                return;
            end
        end
        check($sformatf("%s done cycle", tag), done_seen,
              (s.exp_total >= 0) ? s.exp_total : end_cyc);
        if (s.counting) check($sformatf("%s bl top bits", tag), bl[BL-1 -: 3], 3'b111);
        start = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s idle c%0d", tag, k), {bl, cfg_ready, busy, done, wl, frame_idx}, '0);
            start = 1'b0; cfg_valid = 1'($urandom); cfg_data = DW'($urandom);
        end
        cfg_valid = 1'b0;
    endtask

    scen_t scen [4];
    evec_t evec [7];

    initial begin
        scen[0] = '{counting: 1, stall_len: 0, ign_start: 0, rnd_gaps: 0, exp_total: 4 * FRAME_MIN};
        scen[1] = '{counting: 1, stall_len: 5, ign_start: 1, rnd_gaps: 0, exp_total: 4 * FRAME_MIN + 5};
        scen[2] = '{counting: 0, stall_len: 0, ign_start: 1, rnd_gaps: 1, exp_total: -1};
        scen[3] = '{counting: 0, stall_len: 0, ign_start: 0, rnd_gaps: 1, exp_total: -1};

        // {ready, busy, done, wl, frame_idx, bl} per cycle of the single-word instance.
        evec[0] = '{start: 1, valid: 0, data: 8'h00, exp: {5'b00000, 8'h00}};
        evec[1] = '{start: 0, valid: 1, data: 8'hA5, exp: {5'b11000, 8'h00}};
        evec[2] = '{start: 1, valid: 1, data: 8'h3C, exp: {5'b01000, 8'hA5}};
        evec[3] = '{start: 0, valid: 1, data: 8'h3C, exp: {5'b01010, 8'hA5}};
        evec[4] = '{start: 0, valid: 1, data: 8'h3C, exp: {5'b01000, 8'hA5}};
        evec[5] = '{start: 0, valid: 1, data: 8'h3C, exp: {5'b01100, 8'hA5}};
        evec[6] = '{start: 0, valid: 0, data: 8'h00, exp: {5'b00000, 8'hA5}};

        reset = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        e_start = 1'b0; e_valid = 1'b0; e_data = '0;

        #7 reset = 1'b1;
        #1 check("initial async reset", {bl, wl, cfg_ready, busy, done, frame_idx}, '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        idle_check(3, "post reset");

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("edge c%0d", i), {e_ready, e_busy, e_done, e_wl, e_frame, e_bl}, evec[i].exp);
            e_start = evec[i].start; e_valid = evec[i].valid; e_data = evec[i].data;
        end
        e_start = 1'b0; e_valid = 1'b0;

        for (int i = 0; i < 4; i++) run(scen[i], -1, $sformatf("scen%0d", i));

        run(scen[0], 2 * FRAME_MIN + WORDS + 1, "abort");
        idle_check(3, "after abort");
        run(scen[0], -1, "reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
